// File: rtl/fpu_seq_result_queue.sv
// Purpose : tracks the single in-flight FP div/sqrt op and queues its result for FP writeback.
// Latency : result pulse in cycle N appears on o_wb_valid in cycle N+1.
// Backpr. : head held stable while i_wb_ready is low; o_can_start drops while busy or queue full.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_start_dest_reg     launch of a div/sqrt op and its FP destination
//   i_flush                       squash the in-flight (not yet returned) op
//   i_div_*, i_sqrt_*             one-cycle result pulses with data and fflags
//   o_can_start                   a new op may be launched this cycle
//   o_wb_* / i_wb_ready           head-of-queue valid/ready writeback interface
//   i_rs_valid, i_rs1..i_rs3      decode source regs checked for RAW hazards
//   o_hazard                      a source matches a pending destination
//   o_count                       queue occupancy
//   o_error                       sticky protocol-violation flag
module fpu_seq_result_queue #(
  parameter int FP_WIDTH_D = 64,
  parameter int DEPTH      = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [4:0]                i_start_dest_reg,
  input  logic                      i_flush,
  input  logic                      i_div_valid,
  input  logic [FP_WIDTH_D-1:0]     i_div_result,
  input  logic [4:0]                i_div_flags,
  input  logic                      i_sqrt_valid,
  input  logic [FP_WIDTH_D-1:0]     i_sqrt_result,
  input  logic [4:0]                i_sqrt_flags,
  output logic                      o_can_start,
  output logic                      o_wb_valid,
  input  logic                      i_wb_ready,
  output logic [FP_WIDTH_D-1:0]     o_wb_result,
  output logic [4:0]                o_wb_flags,
  output logic [4:0]                o_wb_dest_reg,
  output logic                      o_wb_is_sqrt,
  input  logic [2:0]                i_rs_valid,
  input  logic [4:0]                i_rs1,
  input  logic [4:0]                i_rs2,
  input  logic [4:0]                i_rs3,
  output logic                      o_hazard,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [FP_WIDTH_D-1:0] result;
    logic [4:0]            flags;
    logic [4:0]            dest;
    logic                  is_sqrt;
  } entry_t;

  // Queue storage; a per-entry valid bit makes the hazard scan independent of pointer math.
  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   ent_vld;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // In-flight tracker.
  logic               inflight;
  logic [4:0]         inflight_dest;
  logic               kill;
  logic               error_q;

  logic               res_v;
  logic               start_acc;
  logic               push_req;
  logic               full;
  logic               push;
  logic               pop;
  logic               err_now;
  entry_t             new_entry;
  entry_t             head;
  logic [4:0]         rs [3];

  assign rs[0] = i_rs1;
  assign rs[1] = i_rs2;
  assign rs[2] = i_rs3;

  assign full        = (count == DEPTH_C);
  assign o_can_start = ~inflight & (count < DEPTH_C);
  assign start_acc   = i_start & o_can_start;
  assign res_v       = i_div_valid | i_sqrt_valid;

  // A result is kept only if it belongs to a live op that is not being squashed this cycle.
  assign push_req    = res_v & inflight & ~kill & ~i_flush;
  assign push        = push_req & ~full;
  assign pop         = o_wb_valid & i_wb_ready;

  assign err_now = (i_div_valid & i_sqrt_valid)
                 | (res_v & ~inflight)
                 | (i_start & ~o_can_start)
                 | (push_req & full);

  // Divider wins when both units pulse together.
  always_comb begin
    new_entry         = '0;
    new_entry.result  = i_div_valid ? i_div_result : i_sqrt_result;
    new_entry.flags   = i_div_valid ? i_div_flags  : i_sqrt_flags;
    new_entry.dest    = inflight_dest;
    new_entry.is_sqrt = ~i_div_valid;
  end

  assign head          = mem[rd_ptr];
  assign o_wb_valid    = (count != '0);
  assign o_wb_result   = head.result;
  assign o_wb_flags    = head.flags;
  assign o_wb_dest_reg = head.dest;
  assign o_wb_is_sqrt  = head.is_sqrt;
  assign o_count       = count;
  assign o_error       = error_q;

  // An entry being popped this cycle is still valid here, so its dest keeps the hazard up
  // until the register-file write has actually happened.
  always_comb begin
    o_hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (i_rs_valid[k]) begin
        if (inflight & ~kill & (rs[k] == inflight_dest)) o_hazard = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          if (ent_vld[e] & (mem[e].dest == rs[k])) o_hazard = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight      <= 1'b0;
      inflight_dest <= '0;
      kill          <= 1'b0;
      error_q       <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      ent_vld       <= '0;
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      // Result return retires the op; a stray start in the same cycle (only possible on a
      // protocol error) takes precedence as the newer op.
      if (res_v) begin
        inflight <= 1'b0;
        kill     <= 1'b0;
      end else if (i_flush & inflight) begin
        kill <= 1'b1;
      end
      // A flush coinciding with a start targets the older op, so the new op stays live.
      if (start_acc) begin
        inflight      <= 1'b1;
        inflight_dest <= i_start_dest_reg;
        kill          <= 1'b0;
      end

      if (err_now) error_q <= 1'b1;

      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        mem[wr_ptr]     <= new_entry;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      // Push and pop never address the same slot: push needs a free slot, pop needs a full one.
      for (int e = 0; e < DEPTH; e++) begin
        if (push && (wr_ptr == PTR_W'(e)))     ent_vld[e] <= 1'b1;
        else if (pop && (rd_ptr == PTR_W'(e))) ent_vld[e] <= 1'b0;
      end

      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fpu_seq_result_queue.sv
module tb_fpu_seq_result_queue;

  localparam int W = 64;
  localparam int DEPTH = 2;

  logic         i_clk;
  logic         i_rst;
  logic         i_start;
  logic [4:0]   i_start_dest_reg;
  logic         i_flush;
  logic         i_div_valid;
  logic [W-1:0] i_div_result;
  logic [4:0]   i_div_flags;
  logic         i_sqrt_valid;
  logic [W-1:0] i_sqrt_result;
  logic [4:0]   i_sqrt_flags;
  logic         o_can_start;
  logic         o_wb_valid;
  logic         i_wb_ready;
  logic [W-1:0] o_wb_result;
  logic [4:0]   o_wb_flags;
  logic [4:0]   o_wb_dest_reg;
  logic         o_wb_is_sqrt;
  logic [2:0]   i_rs_valid;
  logic [4:0]   i_rs1, i_rs2, i_rs3;
  logic         o_hazard;
  logic [1:0]   o_count;
  logic         o_error;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_seq_result_queue #(.FP_WIDTH_D(W), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_start(i_start), .i_start_dest_reg(i_start_dest_reg), .i_flush(i_flush),
    .i_div_valid(i_div_valid), .i_div_result(i_div_result), .i_div_flags(i_div_flags),
    .i_sqrt_valid(i_sqrt_valid), .i_sqrt_result(i_sqrt_result), .i_sqrt_flags(i_sqrt_flags),
    .o_can_start(o_can_start), .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_result(o_wb_result), .o_wb_flags(o_wb_flags), .o_wb_dest_reg(o_wb_dest_reg),
    .o_wb_is_sqrt(o_wb_is_sqrt), .i_rs_valid(i_rs_valid), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_rs3(i_rs3), .o_hazard(o_hazard), .o_count(o_count), .o_error(o_error)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_op(input logic [4:0] d);
    i_start = 1'b1; i_start_dest_reg = d;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    #1;
    n_checks++; if (o_wb_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_wb_valid); else n_pass++;
    n_checks++; if (o_count !== 2'd0) $display("FAIL reset_count got %0d want 0", o_count); else n_pass++;
    n_checks++; if (o_can_start !== 1'b1) $display("FAIL reset_can_start got %b want 1", o_can_start); else n_pass++;
    n_checks++; if (o_error !== 1'b0) $display("FAIL reset_error got %b want 0", o_error); else n_pass++;
    n_checks++; if (o_wb_result !== 64'h0) $display("FAIL reset_result got %h want 0", o_wb_result); else n_pass++;
    n_checks++; if (o_wb_dest_reg !== 5'd0) $display("FAIL reset_dest got %0d want 0", o_wb_dest_reg); else n_pass++;
  endtask

  task automatic test_basic();
    i_wb_ready = 1'b1;
    start_op(5'd5);
    n_checks++; if (o_can_start !== 1'b0) $display("FAIL basic_busy_can_start got %b want 0", o_can_start); else n_pass++;
    repeat (9) tick();
    i_div_valid = 1'b1; i_div_result = 64'h3FF0000000000000; i_div_flags = 5'h00;
    #1;
    n_checks++; if (o_can_start !== 1'b0) $display("FAIL basic_arrival_can_start got %b want 0", o_can_start); else n_pass++;
    n_checks++; if (o_wb_valid !== 1'b0) $display("FAIL basic_arrival_valid got %b want 0", o_wb_valid); else n_pass++;
    tick();
    i_div_valid = 1'b0;
    #1;
    n_checks++; if (o_wb_valid !== 1'b1) $display("FAIL basic_wb_valid got %b want 1", o_wb_valid); else n_pass++;
    n_checks++; if (o_wb_dest_reg !== 5'd5) $display("FAIL basic_dest got %0d want 5", o_wb_dest_reg); else n_pass++;
    n_checks++; if (o_wb_is_sqrt !== 1'b0) $display("FAIL basic_is_sqrt got %b want 0", o_wb_is_sqrt); else n_pass++;
    n_checks++; if (o_wb_result !== 64'h3FF0000000000000) $display("FAIL basic_result got %h want 3ff0000000000000", o_wb_result); else n_pass++;
    n_checks++; if (o_can_start !== 1'b1) $display("FAIL basic_after_can_start got %b want 1", o_can_start); else n_pass++;
    tick();
    n_checks++; if (o_count !== 2'd0) $display("FAIL basic_popped_count got %0d want 0", o_count); else n_pass++;
    i_wb_ready = 1'b0;
  endtask

  task automatic test_flush();
    start_op(5'd7);
    i_rs_valid = 3'b001; i_rs1 = 5'd7;
    #1;
    n_checks++; if (o_hazard !== 1'b1) $display("FAIL flush_hazard_before got %b want 1", o_hazard); else n_pass++;
    tick(); tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    #1;
    n_checks++; if (o_hazard !== 1'b0) $display("FAIL flush_hazard_after got %b want 0", o_hazard); else n_pass++;
    n_checks++; if (o_can_start !== 1'b0) $display("FAIL flush_killed_can_start got %b want 0", o_can_start); else n_pass++;
    tick();
    i_sqrt_valid = 1'b1; i_sqrt_result = 64'h1234; i_sqrt_flags = 5'h01;
    tick();
    i_sqrt_valid = 1'b0;
    #1;
    n_checks++; if (o_wb_valid !== 1'b0) $display("FAIL flush_dropped_valid got %b want 0", o_wb_valid); else n_pass++;
    n_checks++; if (o_count !== 2'd0) $display("FAIL flush_dropped_count got %0d want 0", o_count); else n_pass++;
    n_checks++; if (o_can_start !== 1'b1) $display("FAIL flush_can_start got %b want 1", o_can_start); else n_pass++;
    // Flush together with a new start: the new op must survive.
    i_flush = 1'b1;
    start_op(5'd6);
    i_flush = 1'b0;
    i_rs1 = 5'd6;
    #1;
    n_checks++; if (o_hazard !== 1'b1) $display("FAIL flush_start_hazard got %b want 1", o_hazard); else n_pass++;
    i_sqrt_valid = 1'b1; i_sqrt_result = 64'h5555; i_sqrt_flags = 5'h02;
    tick();
    i_sqrt_valid = 1'b0;
    #1;
    n_checks++; if (o_wb_dest_reg !== 5'd6 || o_wb_valid !== 1'b1) $display("FAIL flush_start_push got dest %0d valid %b want dest 6 valid 1", o_wb_dest_reg, o_wb_valid); else n_pass++;
    n_checks++; if (o_wb_is_sqrt !== 1'b1 || o_wb_flags !== 5'h02) $display("FAIL flush_start_sqrt got is_sqrt %b flags %h want 1 02", o_wb_is_sqrt, o_wb_flags); else n_pass++;
    i_wb_ready = 1'b1;
    tick();
    i_wb_ready = 1'b0;
    i_rs_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    i_wb_ready = 1'b0;
    start_op(5'd1);
    tick();
    i_div_valid = 1'b1; i_div_result = 64'hAAAA; i_div_flags = 5'h01;
    tick();
    i_div_valid = 1'b0;
    start_op(5'd2);
    tick();
    i_sqrt_valid = 1'b1; i_sqrt_result = 64'hBBBB; i_sqrt_flags = 5'h10;
    tick();
    i_sqrt_valid = 1'b0;
    #1;
    n_checks++; if (o_count !== 2'd2) $display("FAIL bp_count_full got %0d want 2", o_count); else n_pass++;
    n_checks++; if (o_can_start !== 1'b0) $display("FAIL bp_full_can_start got %b want 0", o_can_start); else n_pass++;
    tick(); tick();
    n_checks++; if (o_wb_dest_reg !== 5'd1 || o_wb_result !== 64'hAAAA || o_wb_valid !== 1'b1) $display("FAIL bp_head_stable got dest %0d result %h want dest 1 result aaaa", o_wb_dest_reg, o_wb_result); else n_pass++;
    i_wb_ready = 1'b1;
    tick();
    n_checks++; if (o_wb_dest_reg !== 5'd2 || o_wb_result !== 64'hBBBB || o_wb_is_sqrt !== 1'b1) $display("FAIL bp_second got dest %0d result %h sqrt %b want 2 bbbb 1", o_wb_dest_reg, o_wb_result, o_wb_is_sqrt); else n_pass++;
    n_checks++; if (o_count !== 2'd1) $display("FAIL bp_count_one got %0d want 1", o_count); else n_pass++;
    tick();
    n_checks++; if (o_count !== 2'd0 || o_wb_valid !== 1'b0) $display("FAIL bp_drained got count %0d valid %b want 0 0", o_count, o_wb_valid); else n_pass++;
    i_wb_ready = 1'b0;
  endtask

  task automatic test_hazard();
    i_rs_valid = 3'b010; i_rs2 = 5'd9; i_rs1 = 5'd0; i_rs3 = 5'd0;
    start_op(5'd9);
    #1;
    n_checks++; if (o_hazard !== 1'b1) $display("FAIL hz_inflight got %b want 1", o_hazard); else n_pass++;
    i_rs_valid = 3'b000;
    #1;
    n_checks++; if (o_hazard !== 1'b0) $display("FAIL hz_disabled got %b want 0", o_hazard); else n_pass++;
    i_rs_valid = 3'b010;
    i_div_valid = 1'b1; i_div_result = 64'h9999; i_div_flags = 5'h00;
    tick();
    i_div_valid = 1'b0;
    #1;
    n_checks++; if (o_hazard !== 1'b1) $display("FAIL hz_queued got %b want 1", o_hazard); else n_pass++;
    i_rs2 = 5'd8;
    #1;
    n_checks++; if (o_hazard !== 1'b0) $display("FAIL hz_nomatch got %b want 0", o_hazard); else n_pass++;
    i_rs2 = 5'd9; i_wb_ready = 1'b1;
    #1;
    n_checks++; if (o_hazard !== 1'b1) $display("FAIL hz_popping got %b want 1", o_hazard); else n_pass++;
    tick();
    i_wb_ready = 1'b0;
    #1;
    n_checks++; if (o_hazard !== 1'b0 || o_count !== 2'd0) $display("FAIL hz_after_pop got hazard %b count %0d want 0 0", o_hazard, o_count); else n_pass++;
    i_rs_valid = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic [4:0] d;
    i_wb_ready = 1'b0;
    start_op(5'd10);
    i_div_valid = 1'b1; i_div_result = 64'h100; i_div_flags = 5'h00;
    tick();
    i_div_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      d = 5'(10 + k);
      start_op(d);
      i_div_valid = 1'b1; i_div_result = 64'(256 + k); i_wb_ready = 1'b1;
      #1;
      n_checks++; if (o_wb_dest_reg !== d - 5'd1) $display("FAIL b2b_head_before k=%0d got %0d want %0d", k, o_wb_dest_reg, d - 5'd1); else n_pass++;
      tick();
      i_div_valid = 1'b0; i_wb_ready = 1'b0;
      #1;
      n_checks++; if (o_count !== 2'd1) $display("FAIL b2b_count k=%0d got %0d want 1", k, o_count); else n_pass++;
      n_checks++; if (o_wb_dest_reg !== d || o_wb_result !== 64'(256 + k)) $display("FAIL b2b_head_after k=%0d got dest %0d result %h want %0d %h", k, o_wb_dest_reg, o_wb_result, d, 64'(256 + k)); else n_pass++;
    end
    i_wb_ready = 1'b1;
    tick();
    i_wb_ready = 1'b0;
    n_checks++; if (o_count !== 2'd0) $display("FAIL b2b_drained got %0d want 0", o_count); else n_pass++;
  endtask

  task automatic test_error();
    n_checks++; if (o_error !== 1'b0) $display("FAIL err_clean got %b want 0", o_error); else n_pass++;
    i_div_valid = 1'b1; i_div_result = 64'hDEAD;
    tick();
    i_div_valid = 1'b0;
    n_checks++; if (o_error !== 1'b1 || o_count !== 2'd0) $display("FAIL err_stray got error %b count %0d want 1 0", o_error, o_count); else n_pass++;
    repeat (3) tick();
    n_checks++; if (o_error !== 1'b1) $display("FAIL err_sticky got %b want 1", o_error); else n_pass++;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_checks++; if (o_error !== 1'b0) $display("FAIL err_reset got %b want 0", o_error); else n_pass++;
    start_op(5'd3);
    i_div_valid = 1'b1; i_div_result = 64'hC0C0; i_div_flags = 5'h04;
    i_sqrt_valid = 1'b1; i_sqrt_result = 64'hD0D0; i_sqrt_flags = 5'h08;
    tick();
    i_div_valid = 1'b0; i_sqrt_valid = 1'b0;
    n_checks++; if (o_error !== 1'b1 || o_count !== 2'd1) $display("FAIL err_both got error %b count %0d want 1 1", o_error, o_count); else n_pass++;
    n_checks++; if (o_wb_result !== 64'hC0C0 || o_wb_is_sqrt !== 1'b0 || o_wb_flags !== 5'h04 || o_wb_dest_reg !== 5'd3) $display("FAIL err_div_priority got %h sqrt %b flags %h dest %0d want c0c0 0 04 3", o_wb_result, o_wb_is_sqrt, o_wb_flags, o_wb_dest_reg); else n_pass++;
    // Reset while an op is in flight, with a result pulse in the reset cycle.
    start_op(5'd4);
    n_checks++; if (o_can_start !== 1'b0) $display("FAIL err_midop_busy got %b want 0", o_can_start); else n_pass++;
    i_rst = 1'b1; i_div_valid = 1'b1; i_div_result = 64'hEEEE;
    tick();
    i_rst = 1'b0; i_div_valid = 1'b0;
    i_rs_valid = 3'b001; i_rs1 = 5'd4;
    #1;
    n_checks++; if (o_wb_valid !== 1'b0 || o_count !== 2'd0) $display("FAIL rst_mid_queue got valid %b count %0d want 0 0", o_wb_valid, o_count); else n_pass++;
    n_checks++; if (o_can_start !== 1'b1 || o_error !== 1'b0) $display("FAIL rst_mid_state got can_start %b error %b want 1 0", o_can_start, o_error); else n_pass++;
    n_checks++; if (o_wb_result !== 64'h0 || o_wb_dest_reg !== 5'd0 || o_hazard !== 1'b0) $display("FAIL rst_mid_data got result %h dest %0d hazard %b want 0 0 0", o_wb_result, o_wb_dest_reg, o_hazard); else n_pass++;
    i_rs_valid = 3'b000;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_start_dest_reg = '0; i_flush = 1'b0;
    i_div_valid = 1'b0; i_div_result = '0; i_div_flags = '0;
    i_sqrt_valid = 1'b0; i_sqrt_result = '0; i_sqrt_flags = '0;
    i_wb_ready = 1'b0; i_rs_valid = '0; i_rs1 = '0; i_rs2 = '0; i_rs3 = '0;
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_hazard();
    test_back_to_back();
    test_error();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_seq_result_queue.md
Name: fpu_seq_result_queue

Overview:
- Sits directly downstream of the FPU divide/sqrt unit.
- Tracks the single in-flight sequential op: start pulse plus dest reg.
- Captures the one-cycle divider/sqrt result pulse into a small FIFO and presents it to the FP register-file writeback arbiter with a valid/ready handshake.
- Supplies a start-permission signal, RAW hazard detection against pending dest regs, and flush handling for the in-flight op.

Parameters:
- FP_WIDTH_D, 64, width of result datapath (single results arrive already NaN-boxed).
- DEPTH, 2, result FIFO entries (power of two, >=2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  sequential op launched this cycle (div or sqrt)
- i_start_dest_reg  in  5  FP dest reg of launched op
- i_flush  in  1  squash the in-flight (not yet returned) op
- i_div_valid  in  1  divider result pulse
- i_div_result  in  FP_WIDTH_D  divider result
- i_div_flags  in  5  divider fflags (NV,DZ,OF,UF,NX)
- i_sqrt_valid  in  1  sqrt result pulse
- i_sqrt_result  in  FP_WIDTH_D  sqrt result
- i_sqrt_flags  in  5  sqrt fflags
- o_can_start  out  1  a new op may be launched this cycle
- o_wb_valid  out  1  head entry valid
- i_wb_ready  in  1  arbiter accepts head
- o_wb_result  out  FP_WIDTH_D  head result
- o_wb_flags  out  5  head fflags
- o_wb_dest_reg  out  5  head dest reg
- o_wb_is_sqrt  out  1  head came from sqrt
- i_rs_valid  in  3  source-read enables for rs1/rs2/rs3
- i_rs1, i_rs2, i_rs3  in  5 each  FP source regs of instruction in decode/issue
- o_hazard  out  1  a source matches a pending dest
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy
- o_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset: FIFO empty, count 0, inflight 0, kill 0, o_error 0, o_wb_valid 0; o_wb_* data fields 0.
- In-flight tracker:
  - Registers inflight, inflight_dest, kill.
  - Accepted start (i_start & o_can_start): inflight<=1, inflight_dest<=i_start_dest_reg, kill<=0.
  - i_flush while inflight: kill<=1.
  - i_flush with i_start in the same cycle: the start is accepted and is not killed (flush refers to the older op).
- o_can_start = ~inflight & (count < DEPTH); fully combinational from registered state.
  - No start in the cycle a result returns: a start is accepted only from the next cycle.
- Result arrival (res_v = i_div_valid | i_sqrt_valid):
  - Clears inflight and kill next cycle.
  - If kill=0: push {result, flags, inflight_dest, is_sqrt} into FIFO.
  - If kill=1: result is dropped, no push.
  - If i_flush is asserted in the arrival cycle: result is dropped.
  - Divider takes priority if both valids are high; o_error<=1.
  - res_v with inflight=0: dropped, o_error<=1.
  - i_start while o_can_start=0: ignored, o_error<=1.
- FIFO:
  - Registered storage, circular read/write pointers wrapping at DEPTH.
  - Latency: result pulse at cycle N gives o_wb_valid at N+1.
  - Pop on o_wb_valid & i_wb_ready.
  - Push and pop in the same cycle: count unchanged.
  - Push when full is impossible by o_can_start; if it occurs, drop the push and set o_error<=1.
  - o_wb_* reflect head entry; held stable while o_wb_valid & ~i_wb_ready.
- Hazard (combinational):
  - o_hazard = OR over k of i_rs_valid[k] & (rs_k == inflight_dest & inflight & ~kill, or rs_k == dest of any valid FIFO entry).
  - f0 is a real register; no zero exemption.
  - A matching entry popped in the current cycle still asserts o_hazard this cycle.
- Flush does not affect queued entries: they belong to committed ops.
- Reset mid-operation: all state cleared; a result pulse arriving in the reset cycle is ignored.
- o_error cleared only by reset.

Test Plan:
- Reset, i_start dest=5, i_div_valid 10 cycles later with result 0x3FF0000000000000, flags 0, i_wb_ready=1 -> o_wb_valid one cycle after pulse, dest 5, is_sqrt 0; o_can_start 0 while inflight, 1 after.
- Start dest=7, i_flush 3 cycles later, then i_sqrt_valid -> no push, o_wb_valid stays 0, o_can_start returns 1, o_hazard for rs1=7 drops after flush.
- i_wb_ready=0; two ops (dest 1 then 2) return -> count 2, o_can_start 0, head stable dest 1; raise ready -> dests 1 then 2 in order, count 0.
- i_rs_valid=3'b010, rs2=9 with inflight dest 9 -> o_hazard 1; rs2=9 with dest 9 queued -> 1; rs_valid=0 -> 0.
- Push and pop in the same cycle with count 1 -> count stays 1, correct data order after pointer wrap (exercise 5 ops with DEPTH=2).
- i_div_valid with no inflight, or div and sqrt simultaneously -> o_error 1 and sticky until i_rst; assert reset mid-inflight -> all outputs back to reset values.
